exemem_reg: RTL and testbench
=============================

Name: exemem_reg

Overview:
- EXE/MEM pipeline register; sits directly downstream of the ID/EXE register and the EXE datapath, and feeds the data-memory port and the MEM/WB register.
- Captures EXE results, resolves the rd write-back source, and registers store byte-lane alignment plus misalignment detection.
- Hosts the architectural cycle and instret counters consumed by the CSR unit.

Parameters:
- XLEN, 32: datapath width.
- CNT_W, 64: width of the cycle and instret counters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- EXE_valid  input  1  the EXE slot holds a real instruction (0 = bubble).
- EXE_flush  input  1  insert a bubble into MEM this cycle.
- im_stall  input  1  hold request from the instruction memory.
- dm_stall  input  1  hold request from the data memory.
- CSR_stall  input  1  hold request from the CSR unit.
- CSR_reset  input  1  synchronous pipeline clear (trap or redirect).
- EXE_pc  input  XLEN  PC of the EXE instruction.
- EXE_imm  input  XLEN  immediate.
- alu_out  input  XLEN  ALU result; also the memory address.
- rs2_data  input  XLEN  integer store data (already forwarded).
- frs2_data  input  XLEN  FP store data.
- csr_rdata  input  XLEN  CSR read value.
- EXE_write_addr  input  5  rd index.
- EXE_funct3  input  3  access size and sign.
- EXE_PCtoRegSrc  input  1  PC path select: 1 = pc+imm, 0 = pc+4.
- EXE_RDSrc  input  1  1 = PC path, 0 = ALU.
- EXE_CSRSel  input  1  rd source is csr_rdata; takes priority over RDSrc.
- EXE_MemtoReg  input  1  load instruction.
- EXE_MemRead  input  1  memory read request.
- EXE_MenWrite  input  1  memory write request.
- EXE_RegWrite  input  1  integer register write.
- EXE_f_RegWrite  input  1  FP register write.
- EXE_Memoryin_f  input  1  store data taken from frs2_data.
- MEM_pc  output  XLEN  registered PC.
- MEM_alu_out  output  XLEN  registered address/ALU result.
- MEM_rd_data  output  XLEN  resolved non-load write-back value.
- MEM_store_data  output  XLEN  lane-shifted store data.
- MEM_byte_en  output  4  active-high store byte enables.
- MEM_write_addr  output  5  rd index.
- MEM_funct3  output  3  access size and sign.
- MEM_MemtoReg  output  1  load instruction.
- MEM_MemRead  output  1  memory read request.
- MEM_MemWrite  output  1  memory write request.
- MEM_RegWrite  output  1  integer register write.
- MEM_f_RegWrite  output  1  FP register write.
- MEM_valid  output  1  the MEM slot holds a real instruction.
- MEM_misalign  output  1  the memory access is misaligned.
- cycle_cnt  output  CNT_W  cycle counter.
- instret_cnt  output  CNT_W  retired-instruction counter.

Behaviour:
- Priority each edge: reset (asynchronous) > CSR_reset > stall (im_stall | dm_stall | CSR_stall) > EXE_flush > load.
- Reset: all outputs become 0, including both counters.
- CSR_reset:
  - Clears every pipeline output to 0.
  - Does not touch the counters, except that cycle_cnt still increments.
- Stall: every pipeline output holds its value, including MEM_valid.
- EXE_flush:
  - Clears MEM_valid, MEM_MemRead, MEM_MemWrite, MEM_RegWrite, MEM_f_RegWrite, MEM_MemtoReg, MEM_misalign and MEM_byte_en.
  - Data fields hold their previous values.
- Load:
  - All fields capture their inputs; MEM_valid <= EXE_valid.
  - Control bits are ANDed with EXE_valid.
  - Latency is 1 cycle.
- MEM_rd_data select:
  - EXE_CSRSel = 1 → csr_rdata.
  - else EXE_RDSrc = 1 → (EXE_PCtoRegSrc ? EXE_pc + EXE_imm : EXE_pc + 4).
  - else → alu_out.
  - Additions are modulo 2^XLEN.
- Store data source: EXE_Memoryin_f ? frs2_data : rs2_data; call it sd.
- Store alignment by funct3:
  - SB: byte_en = 4'b0001 << a[1:0]; store_data = sd[7:0] << 8*a[1:0].
  - SH: byte_en = 4'b0011 << a[1:0]; store_data = sd[15:0] << 8*a[1:0]; misaligned if a[0] = 1.
  - SW: byte_en = 4'b1111; store_data = sd; misaligned if a[1:0] != 0.
  - Any other funct3 with MenWrite: byte_en = 0.
- Load misalignment: LH/LHU when a[0] = 1; LW when a[1:0] != 0.
- On misalignment: MEM_misalign = 1, MEM_MemWrite = 0, MEM_MemRead = 0, MEM_byte_en = 0, MEM_RegWrite = 0, MEM_f_RegWrite = 0.
- cycle_cnt: +1 every edge not in reset, including during stalls; wraps to 0 from all-ones.
- instret_cnt:
  - +1 on a load edge with EXE_valid = 1 and no misalignment.
  - Not incremented on stall, flush or CSR_reset edges.
  - Wraps to 0 from all-ones.
- Reset mid-stall: outputs clear immediately and asynchronously; the stall has no effect until reset deasserts.

Optional Feature:
- Macro: EXEMEM_PERF_CNT_EN.
- Defined: cycle_cnt and instret_cnt are implemented as above.
- Undefined: both counter outputs are tied to 0 and no counter flops are synthesized.

Decomposition:
- Shared package exemem_pkg:
  - funct3 constants F3_B = 3'b000, F3_H = 3'b001, F3_W = 3'b010, F3_BU = 3'b100, F3_HU = 3'b101.
  - typedef byte_en_t, logic [3:0].
  - localparam PC_INC = 4.
- One combinational sub-module, mem_store_align: inputs sd, addr[1:0], funct3, write, read; outputs byte_en, store_data, misalign.

Test Plan:
- SB: sd = 32'h000000AB, alu_out = 32'h1003, MenWrite = 1 → next cycle MEM_byte_en = 4'b1000, MEM_store_data = 32'hAB000000, MEM_MemWrite = 1.
- SW: alu_out = 32'h1002 → MEM_misalign = 1, MEM_MemWrite = 0, MEM_byte_en = 0, instret_cnt unchanged.
- JAL-style: RDSrc = 1, PCtoRegSrc = 0, EXE_pc = 32'hFFFFFFFC → MEM_rd_data = 32'h0. Then CSRSel = 1, csr_rdata = 32'h55 → MEM_rd_data = 32'h55.
- Stall: dm_stall held 3 cycles → all MEM outputs constant, cycle_cnt +3, instret_cnt +0. Releasing the stall with EXE_valid = 1 → instret_cnt +1.
- EXE_flush and CSR_reset:
  - EXE_flush with EXE_RegWrite = 1 → MEM_RegWrite = 0, MEM_valid = 0.
  - CSR_reset asserted together with a stall → all MEM outputs 0, counters not cleared.
- Async reset asserted mid-cycle with counters nonzero → all outputs 0 before the next clk edge. With cycle_cnt forced to all-ones and one more edge → cycle_cnt = 0.

Source files
------------

// File: rtl/exemem_pkg.sv
// Shared definitions for the EXE/MEM pipeline register slice: funct3
// encodings for load/store access sizes, the byte-enable type and the
// fall-through PC increment used for link-register values.
package exemem_pkg;

    // Load/store access-size encodings carried in funct3.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // One enable per byte lane of the 32-bit data-memory port.
    typedef logic [3:0] byte_en_t;

    // Distance from an instruction to its sequential successor.
    localparam int PC_INC = 4;

    // Bit offset of the addressed byte lane inside a word.
    function automatic logic [4:0] lane_shift(input logic [1:0] addr);
        return {addr, 3'b000};
    endfunction

endpackage

// File: rtl/mem_store_align.sv
// Store lane alignment and access misalignment detection.
// Purely combinational: moves store data into the addressed byte lanes,
// produces matching byte enables and flags halfword/word accesses that
// do not sit on their natural boundary (for both loads and stores).
module mem_store_align
    import exemem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] sd,
    input  logic [1:0]      addr,
    input  logic [2:0]      funct3,
    input  logic            write,
    input  logic            read,
    output byte_en_t        byte_en,
    output logic [XLEN-1:0] store_data,
    output logic            misalign
);

    logic [4:0] laneShift;
    logic       storeMis;
    logic       loadMis;
    byte_en_t   laneEn;

    assign laneShift = lane_shift(addr);

    // Place the store operand in its byte lanes and work out the raw enables.
    always_comb begin
        laneEn     = '0;
        store_data = sd;
        storeMis   = 1'b0;
        case (funct3)
            F3_B: begin
                laneEn     = 4'b0001 << addr;
                store_data = XLEN'(sd[7:0]) << laneShift;
            end
            F3_H: begin
                laneEn     = 4'b0011 << addr;
                store_data = XLEN'(sd[15:0]) << laneShift;
                storeMis   = addr[0];
            end
            F3_W: begin
                laneEn     = 4'b1111;
                storeMis   = |addr;
            end
            default: begin
                laneEn     = '0;
            end
        endcase
    end

    // Loads only care about the natural alignment of halfwords and words.
    always_comb begin
        loadMis = 1'b0;
        case (funct3)
            F3_H, F3_HU: loadMis = addr[0];
            F3_W:        loadMis = |addr;
            default:     loadMis = 1'b0;
        endcase
    end

    // A misaligned access must never strobe the memory, so enables drop too.
    always_comb begin
        misalign = (write & storeMis) | (read & loadMis);
        byte_en  = '0;
        if (write && !misalign) begin
            byte_en = laneEn;
        end
    end

endmodule

// File: rtl/exemem_reg.sv
// EXE/MEM pipeline register.
// Captures the EXE-stage results, resolves the non-load write-back value,
// registers store lane alignment and misalignment, and hosts the cycle and
// instret counters read by the CSR unit.
// Optional build macro EXEMEM_PERF_CNT_EN: when defined the counters are
// implemented; otherwise both counter outputs are tied to zero.
module exemem_reg
    import exemem_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             EXE_valid,
    input  logic             EXE_flush,
    input  logic             im_stall,
    input  logic             dm_stall,
    input  logic             CSR_stall,
    input  logic             CSR_reset,
    input  logic [XLEN-1:0]  EXE_pc,
    input  logic [XLEN-1:0]  EXE_imm,
    input  logic [XLEN-1:0]  alu_out,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [XLEN-1:0]  frs2_data,
    input  logic [XLEN-1:0]  csr_rdata,
    input  logic [4:0]       EXE_write_addr,
    input  logic [2:0]       EXE_funct3,
    input  logic             EXE_PCtoRegSrc,
    input  logic             EXE_RDSrc,
    input  logic             EXE_CSRSel,
    input  logic             EXE_MemtoReg,
    input  logic             EXE_MemRead,
    input  logic             EXE_MenWrite,
    input  logic             EXE_RegWrite,
    input  logic             EXE_f_RegWrite,
    input  logic             EXE_Memoryin_f,
    output logic [XLEN-1:0]  MEM_pc,
    output logic [XLEN-1:0]  MEM_alu_out,
    output logic [XLEN-1:0]  MEM_rd_data,
    output logic [XLEN-1:0]  MEM_store_data,
    output logic [3:0]       MEM_byte_en,
    output logic [4:0]       MEM_write_addr,
    output logic [2:0]       MEM_funct3,
    output logic             MEM_MemtoReg,
    output logic             MEM_MemRead,
    output logic             MEM_MemWrite,
    output logic             MEM_RegWrite,
    output logic             MEM_f_RegWrite,
    output logic             MEM_valid,
    output logic             MEM_misalign,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    logic            stall;
    logic [XLEN-1:0] storeSrc;
    logic [XLEN-1:0] pcPlusImm;
    logic [XLEN-1:0] pcPlusInc;
    byte_en_t        alignByteEn;
    logic [XLEN-1:0] alignStoreData;
    logic            alignMis;

    logic [XLEN-1:0] rdData_d;
    logic            memtoReg_d;
    logic            memRead_d;
    logic            memWrite_d;
    logic            regWrite_d;
    logic            fRegWrite_d;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] aluOut_q;
    logic [XLEN-1:0] rdData_q;
    logic [XLEN-1:0] storeData_q;
    byte_en_t        byteEn_q;
    logic [4:0]      writeAddr_q;
    logic [2:0]      funct3_q;
    logic            memtoReg_q;
    logic            memRead_q;
    logic            memWrite_q;
    logic            regWrite_q;
    logic            fRegWrite_q;
    logic            valid_q;
    logic            misalign_q;

    assign stall     = im_stall | dm_stall | CSR_stall;
    assign storeSrc  = EXE_Memoryin_f ? frs2_data : rs2_data;
    assign pcPlusImm = EXE_pc + EXE_imm;
    assign pcPlusInc = EXE_pc + XLEN'(PC_INC);

    // Request gating uses EXE_valid so a bubble can never flag misalignment.
    mem_store_align #(
        .XLEN       (XLEN)
    ) u_store_align (
        .sd         (storeSrc),
        .addr       (alu_out[1:0]),
        .funct3     (EXE_funct3),
        .write      (EXE_MenWrite & EXE_valid),
        .read       (EXE_MemRead & EXE_valid),
        .byte_en    (alignByteEn),
        .store_data (alignStoreData),
        .misalign   (alignMis)
    );

    // Resolve the non-load write-back value: CSR read beats the PC path, which beats the ALU.
    always_comb begin
        rdData_d = alu_out;
        if (EXE_CSRSel) begin
            rdData_d = csr_rdata;
        end else if (EXE_RDSrc) begin
            rdData_d = EXE_PCtoRegSrc ? pcPlusImm : pcPlusInc;
        end
    end

    // Control bits only survive for real instructions; a misaligned access is squashed.
    always_comb begin
        memtoReg_d  = EXE_MemtoReg   & EXE_valid;
        memRead_d   = EXE_MemRead    & EXE_valid & ~alignMis;
        memWrite_d  = EXE_MenWrite   & EXE_valid & ~alignMis;
        regWrite_d  = EXE_RegWrite   & EXE_valid & ~alignMis;
        fRegWrite_d = EXE_f_RegWrite & EXE_valid & ~alignMis;
    end

    // Pipeline register: reset and CSR_reset clear, stall holds, flush drops control only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= '0;
            aluOut_q    <= '0;
            rdData_q    <= '0;
            storeData_q <= '0;
            byteEn_q    <= '0;
            writeAddr_q <= '0;
            funct3_q    <= '0;
            memtoReg_q  <= 1'b0;
            memRead_q   <= 1'b0;
            memWrite_q  <= 1'b0;
            regWrite_q  <= 1'b0;
            fRegWrite_q <= 1'b0;
            valid_q     <= 1'b0;
            misalign_q  <= 1'b0;
        end else if (CSR_reset) begin
            pc_q        <= '0;
            aluOut_q    <= '0;
            rdData_q    <= '0;
            storeData_q <= '0;
            byteEn_q    <= '0;
            writeAddr_q <= '0;
            funct3_q    <= '0;
            memtoReg_q  <= 1'b0;
            memRead_q   <= 1'b0;
            memWrite_q  <= 1'b0;
            regWrite_q  <= 1'b0;
            fRegWrite_q <= 1'b0;
            valid_q     <= 1'b0;
            misalign_q  <= 1'b0;
        end else if (!stall) begin
            if (EXE_flush) begin
                byteEn_q    <= '0;
                memtoReg_q  <= 1'b0;
                memRead_q   <= 1'b0;
                memWrite_q  <= 1'b0;
                regWrite_q  <= 1'b0;
                fRegWrite_q <= 1'b0;
                valid_q     <= 1'b0;
                misalign_q  <= 1'b0;
            end else begin
                pc_q        <= EXE_pc;
                aluOut_q    <= alu_out;
                rdData_q    <= rdData_d;
                storeData_q <= alignStoreData;
                byteEn_q    <= alignByteEn;
                writeAddr_q <= EXE_write_addr;
                funct3_q    <= EXE_funct3;
                memtoReg_q  <= memtoReg_d;
                memRead_q   <= memRead_d;
                memWrite_q  <= memWrite_d;
                regWrite_q  <= regWrite_d;
                fRegWrite_q <= fRegWrite_d;
                valid_q     <= EXE_valid;
                misalign_q  <= alignMis;
            end
        end
    end

    assign MEM_pc         = pc_q;
    assign MEM_alu_out    = aluOut_q;
    assign MEM_rd_data    = rdData_q;
    assign MEM_store_data = storeData_q;
    assign MEM_byte_en    = byteEn_q;
    assign MEM_write_addr = writeAddr_q;
    assign MEM_funct3     = funct3_q;
    assign MEM_MemtoReg   = memtoReg_q;
    assign MEM_MemRead    = memRead_q;
    assign MEM_MemWrite   = memWrite_q;
    assign MEM_RegWrite   = regWrite_q;
    assign MEM_f_RegWrite = fRegWrite_q;
    assign MEM_valid      = valid_q;
    assign MEM_misalign   = misalign_q;

`ifdef EXEMEM_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] cycle_d;
    logic [CNT_W-1:0] instret_q;
    logic [CNT_W-1:0] instret_d;
    logic             retire;

    // An instruction retires only on a genuine load edge of a valid, aligned instruction.
    assign retire    = ~CSR_reset & ~stall & ~EXE_flush & EXE_valid & ~alignMis;
    assign cycle_d   = cycle_q + CNT_W'(1);
    assign instret_d = retire ? instret_q + CNT_W'(1) : instret_q;

    // Counters survive CSR_reset; cycle keeps running through stalls and wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_exemem_reg.sv
// Self-checking bench for exemem_reg: store alignment, load misalignment,
// write-back source selection, stall/flush/CSR_reset priority and the
// asynchronous reset. Counter expectations follow EXEMEM_PERF_CNT_EN.
module tb_exemem_reg;
    import exemem_pkg::*;

    localparam int XLEN  = 32;
    localparam int CNT_W = 64;
`ifdef EXEMEM_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             EXE_valid, EXE_flush, im_stall, dm_stall, CSR_stall, CSR_reset;
    logic [XLEN-1:0]  EXE_pc, EXE_imm, alu_out, rs2_data, frs2_data, csr_rdata;
    logic [4:0]       EXE_write_addr;
    logic [2:0]       EXE_funct3;
    logic             EXE_PCtoRegSrc, EXE_RDSrc, EXE_CSRSel, EXE_MemtoReg, EXE_MemRead;
    logic             EXE_MenWrite, EXE_RegWrite, EXE_f_RegWrite, EXE_Memoryin_f;
    logic [XLEN-1:0]  MEM_pc, MEM_alu_out, MEM_rd_data, MEM_store_data;
    logic [3:0]       MEM_byte_en;
    logic [4:0]       MEM_write_addr;
    logic [2:0]       MEM_funct3;
    logic             MEM_MemtoReg, MEM_MemRead, MEM_MemWrite, MEM_RegWrite;
    logic             MEM_f_RegWrite, MEM_valid, MEM_misalign;
    logic [CNT_W-1:0] cycle_cnt, instret_cnt;

    exemem_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .EXE_valid(EXE_valid), .EXE_flush(EXE_flush),
        .im_stall(im_stall), .dm_stall(dm_stall), .CSR_stall(CSR_stall), .CSR_reset(CSR_reset),
        .EXE_pc(EXE_pc), .EXE_imm(EXE_imm), .alu_out(alu_out), .rs2_data(rs2_data),
        .frs2_data(frs2_data), .csr_rdata(csr_rdata), .EXE_write_addr(EXE_write_addr),
        .EXE_funct3(EXE_funct3), .EXE_PCtoRegSrc(EXE_PCtoRegSrc), .EXE_RDSrc(EXE_RDSrc),
        .EXE_CSRSel(EXE_CSRSel), .EXE_MemtoReg(EXE_MemtoReg), .EXE_MemRead(EXE_MemRead),
        .EXE_MenWrite(EXE_MenWrite), .EXE_RegWrite(EXE_RegWrite), .EXE_f_RegWrite(EXE_f_RegWrite),
        .EXE_Memoryin_f(EXE_Memoryin_f), .MEM_pc(MEM_pc), .MEM_alu_out(MEM_alu_out),
        .MEM_rd_data(MEM_rd_data), .MEM_store_data(MEM_store_data), .MEM_byte_en(MEM_byte_en),
        .MEM_write_addr(MEM_write_addr), .MEM_funct3(MEM_funct3), .MEM_MemtoReg(MEM_MemtoReg),
        .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .MEM_RegWrite(MEM_RegWrite),
        .MEM_f_RegWrite(MEM_f_RegWrite), .MEM_valid(MEM_valid), .MEM_misalign(MEM_misalign),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    typedef struct packed {
        logic        valid;
        logic        memRead;
        logic        memWrite;
        logic        regWrite;
        logic        fRegWrite;
        logic        misalign;
        logic [3:0]  byteEn;
        logic [31:0] storeData;
        logic [31:0] rdData;
    } exp_t;

    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic        useF;
        logic [3:0]  be;
        logic [31:0] data;
        logic        mis;
    } store_vec_t;

    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic        fp;
        logic        mis;
    } load_vec_t;

    typedef struct packed {
        logic        valid;
        logic        csrSel;
        logic        rdSrc;
        logic        pcToReg;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] alu;
        logic [31:0] csr;
        logic [31:0] rd;
    } rd_vec_t;

    exp_t         sbq[$];
    int           vectors = 0;
    int           miscompares = 0;
    logic [63:0]  expCycle;
    logic [63:0]  expInstret;
    logic [9:0]   ctrlOut;
    logic [146:0] pipeAll;

    assign ctrlOut = {MEM_valid, MEM_MemRead, MEM_MemWrite, MEM_RegWrite, MEM_f_RegWrite,
                      MEM_misalign, MEM_byte_en};
    assign pipeAll = {MEM_pc, MEM_alu_out, MEM_rd_data, MEM_store_data, MEM_byte_en,
                      MEM_write_addr, MEM_funct3, MEM_MemtoReg, MEM_MemRead, MEM_MemWrite,
                      MEM_RegWrite, MEM_f_RegWrite, MEM_valid, MEM_misalign};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [63:0] cntExp(input logic [63:0] v);
        return PERF ? v : 64'd0;
    endfunction

    function automatic logic [9:0] ctrlExp(input exp_t e);
        return {e.valid, e.memRead, e.memWrite, e.regWrite, e.fRegWrite, e.misalign, e.byteEn};
    endfunction

    function automatic store_vec_t mkStore(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] sd, input logic useF,
                                           input logic [3:0] be, input logic [31:0] data,
                                           input logic mis);
        store_vec_t v;
        v.f3 = f3; v.addr = addr; v.sd = sd; v.useF = useF; v.be = be; v.data = data; v.mis = mis;
        return v;
    endfunction

    function automatic load_vec_t mkLoad(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic fp, input logic mis);
        load_vec_t v;
        v.f3 = f3; v.addr = addr; v.fp = fp; v.mis = mis;
        return v;
    endfunction

    function automatic rd_vec_t mkRd(input logic valid, input logic csrSel, input logic rdSrc,
                                     input logic pcToReg, input logic [31:0] pc,
                                     input logic [31:0] imm, input logic [31:0] alu,
                                     input logic [31:0] csr, input logic [31:0] rd);
        rd_vec_t v;
        v.valid = valid; v.csrSel = csrSel; v.rdSrc = rdSrc; v.pcToReg = pcToReg;
        v.pc = pc; v.imm = imm; v.alu = alu; v.csr = csr; v.rd = rd;
        return v;
    endfunction

    task automatic applyStimulus();
        EXE_valid = 0; EXE_flush = 0; im_stall = 0; dm_stall = 0; CSR_stall = 0; CSR_reset = 0;
        EXE_pc = '0; EXE_imm = '0; alu_out = '0; rs2_data = '0; frs2_data = '0; csr_rdata = '0;
        EXE_write_addr = '0; EXE_funct3 = '0; EXE_PCtoRegSrc = 0; EXE_RDSrc = 0; EXE_CSRSel = 0;
        EXE_MemtoReg = 0; EXE_MemRead = 0; EXE_MenWrite = 0; EXE_RegWrite = 0;
        EXE_f_RegWrite = 0; EXE_Memoryin_f = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        expCycle = expCycle + 64'd1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        applyStimulus();
        expCycle = '0;
        expInstret = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if (pipeAll !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_pipe: got %h required 0", pipeAll);
        end
        vectors++;
        if ({cycle_cnt, instret_cnt} !== 128'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_cnt: got %h/%h required 0/0", cycle_cnt, instret_cnt);
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (cycle_cnt !== cntExp(expCycle)) begin
            miscompares++;
            $display("[TB] FAIL first_cycle: got %0d required %0d", cycle_cnt, cntExp(expCycle));
        end
    endtask

    task automatic test_store_align();
        store_vec_t v[$];
        exp_t e;
        v.push_back(mkStore(F3_B, 32'h1003, 32'h000000AB, 1'b0, 4'b1000, 32'hAB000000, 1'b0));
        v.push_back(mkStore(F3_B, 32'h1000, 32'h12345678, 1'b0, 4'b0001, 32'h00000078, 1'b0));
        v.push_back(mkStore(F3_H, 32'h1002, 32'h0000BEEF, 1'b0, 4'b1100, 32'hBEEF0000, 1'b0));
        v.push_back(mkStore(F3_H, 32'h1000, 32'hCAFEF00D, 1'b1, 4'b0011, 32'h0000F00D, 1'b0));
        v.push_back(mkStore(F3_H, 32'h1001, 32'h00001234, 1'b0, 4'b0000, 32'h0, 1'b1));
        v.push_back(mkStore(F3_W, 32'h1004, 32'hDEADBEEF, 1'b0, 4'b1111, 32'hDEADBEEF, 1'b0));
        v.push_back(mkStore(F3_W, 32'h1002, 32'h01020304, 1'b0, 4'b0000, 32'h0, 1'b1));
        v.push_back(mkStore(3'b011, 32'h1000, 32'h0BADC0DE, 1'b0, 4'b0000, 32'h0, 1'b0));
        v.push_back(mkStore(F3_B, 32'h1001, 32'h000000C3, 1'b1, 4'b0010, 32'h0000C300, 1'b0));
        foreach (v[i]) begin
            applyStimulus();
            EXE_valid = 1; EXE_MenWrite = 1; EXE_funct3 = v[i].f3; alu_out = v[i].addr;
            EXE_Memoryin_f = v[i].useF;
            rs2_data  = v[i].useF ? ~v[i].sd : v[i].sd;
            frs2_data = v[i].useF ? v[i].sd : ~v[i].sd;
            e = '0;
            e.valid = 1'b1; e.memWrite = ~v[i].mis; e.misalign = v[i].mis;
            e.byteEn = v[i].be; e.storeData = v[i].data;
            sbq.push_back(e);
            if (!v[i].mis) expInstret = expInstret + 64'd1;
            tick();
            e = sbq.pop_front();
            vectors++;
            if (ctrlOut !== ctrlExp(e)) begin
                miscompares++;
                $display("[TB] FAIL store_ctrl[%0d]: got %b required %b", i, ctrlOut, ctrlExp(e));
            end
            if (e.byteEn != 4'b0000) begin
                vectors++;
                if (MEM_store_data !== e.storeData) begin
                    miscompares++;
                    $display("[TB] FAIL store_data[%0d]: got %h required %h", i, MEM_store_data,
                             e.storeData);
                end
            end
            vectors++;
            if (instret_cnt !== cntExp(expInstret)) begin
                miscompares++;
                $display("[TB] FAIL store_instret[%0d]: got %0d required %0d", i, instret_cnt,
                         cntExp(expInstret));
            end
        end
    endtask

    task automatic test_load_misalign();
        load_vec_t v[$];
        exp_t e;
        v.push_back(mkLoad(F3_H,  32'h2001, 1'b0, 1'b1));
        v.push_back(mkLoad(F3_HU, 32'h2003, 1'b0, 1'b1));
        v.push_back(mkLoad(F3_W,  32'h2002, 1'b0, 1'b1));
        v.push_back(mkLoad(F3_W,  32'h2002, 1'b1, 1'b1));
        v.push_back(mkLoad(F3_W,  32'h2000, 1'b0, 1'b0));
        v.push_back(mkLoad(F3_HU, 32'h2002, 1'b0, 1'b0));
        v.push_back(mkLoad(F3_B,  32'h2003, 1'b0, 1'b0));
        v.push_back(mkLoad(F3_BU, 32'h2001, 1'b0, 1'b0));
        v.push_back(mkLoad(F3_W,  32'h2004, 1'b1, 1'b0));
        foreach (v[i]) begin
            applyStimulus();
            EXE_valid = 1; EXE_MemRead = 1; EXE_MemtoReg = 1; EXE_funct3 = v[i].f3;
            alu_out = v[i].addr; EXE_RegWrite = ~v[i].fp; EXE_f_RegWrite = v[i].fp;
            e = '0;
            e.valid = 1'b1; e.memRead = ~v[i].mis; e.misalign = v[i].mis;
            e.regWrite = ~v[i].fp & ~v[i].mis; e.fRegWrite = v[i].fp & ~v[i].mis;
            sbq.push_back(e);
            if (!v[i].mis) expInstret = expInstret + 64'd1;
            tick();
            e = sbq.pop_front();
            vectors++;
            if (ctrlOut !== ctrlExp(e)) begin
                miscompares++;
                $display("[TB] FAIL load_ctrl[%0d]: got %b required %b", i, ctrlOut, ctrlExp(e));
            end
        end
        vectors++;
        if (instret_cnt !== cntExp(expInstret)) begin
            miscompares++;
            $display("[TB] FAIL load_instret: got %0d required %0d", instret_cnt, cntExp(expInstret));
        end
    endtask

    task automatic test_rd_select();
        rd_vec_t v[$];
        exp_t e;
        v.push_back(mkRd(1, 0, 1, 0, 32'hFFFFFFFC, 32'h0, 32'hDEAD0000, 32'h0, 32'h00000000));
        v.push_back(mkRd(1, 1, 1, 0, 32'hFFFFFFFC, 32'h0, 32'hDEAD0000, 32'h55, 32'h00000055));
        v.push_back(mkRd(1, 0, 1, 1, 32'h00000100, 32'hFFFFFFF0, 32'hDEAD0000, 32'h0, 32'h000000F0));
        v.push_back(mkRd(1, 0, 0, 1, 32'h00000100, 32'hFFFFFFF0, 32'h12345678, 32'h99, 32'h12345678));
        v.push_back(mkRd(0, 0, 0, 0, 32'h00000200, 32'h0, 32'h0000ABCD, 32'h0, 32'h0000ABCD));
        foreach (v[i]) begin
            applyStimulus();
            EXE_valid = v[i].valid; EXE_RegWrite = 1; EXE_CSRSel = v[i].csrSel;
            EXE_RDSrc = v[i].rdSrc; EXE_PCtoRegSrc = v[i].pcToReg; EXE_pc = v[i].pc;
            EXE_imm = v[i].imm; alu_out = v[i].alu; csr_rdata = v[i].csr;
            EXE_write_addr = 5'(i + 3); EXE_funct3 = 3'(i);
            e = '0;
            e.valid = v[i].valid; e.regWrite = v[i].valid; e.rdData = v[i].rd;
            sbq.push_back(e);
            if (v[i].valid) expInstret = expInstret + 64'd1;
            tick();
            e = sbq.pop_front();
            vectors++;
            if (MEM_rd_data !== e.rdData) begin
                miscompares++;
                $display("[TB] FAIL rd_data[%0d]: got %h required %h", i, MEM_rd_data, e.rdData);
            end
            vectors++;
            if (ctrlOut !== ctrlExp(e)) begin
                miscompares++;
                $display("[TB] FAIL rd_ctrl[%0d]: got %b required %b", i, ctrlOut, ctrlExp(e));
            end
            vectors++;
            if ({MEM_pc, MEM_write_addr, MEM_funct3} !== {v[i].pc, 5'(i + 3), 3'(i)}) begin
                miscompares++;
                $display("[TB] FAIL rd_fields[%0d]: got %h/%0d/%0d required %h/%0d/%0d", i, MEM_pc,
                         MEM_write_addr, MEM_funct3, v[i].pc, i + 3, i);
            end
        end
        vectors++;
        if (instret_cnt !== cntExp(expInstret)) begin
            miscompares++;
            $display("[TB] FAIL rd_instret: got %0d required %0d", instret_cnt, cntExp(expInstret));
        end
    endtask

    task automatic test_stall();
        exp_t e;
        exp_t held;
        applyStimulus();
        EXE_valid = 1; EXE_MenWrite = 1; EXE_funct3 = F3_W; alu_out = 32'h2000;
        rs2_data = 32'h11223344;
        held = '0;
        held.valid = 1; held.memWrite = 1; held.byteEn = 4'b1111; held.storeData = 32'h11223344;
        sbq.push_back(held);
        expInstret = expInstret + 64'd1;
        tick();
        e = sbq.pop_front();
        vectors++;
        if ({ctrlOut, MEM_store_data} !== {ctrlExp(e), e.storeData}) begin
            miscompares++;
            $display("[TB] FAIL stall_pre: got %b/%h required %b/%h", ctrlOut, MEM_store_data,
                     ctrlExp(e), e.storeData);
        end
        for (int k = 0; k < 5; k++) begin
            applyStimulus();
            EXE_valid = 1; EXE_MenWrite = 1; EXE_funct3 = F3_B; alu_out = 32'h3001;
            rs2_data = 32'h000000A5;
            dm_stall = (k < 3); im_stall = (k == 3); CSR_stall = (k == 4); EXE_flush = (k == 4);
            sbq.push_back(held);
            tick();
            e = sbq.pop_front();
            vectors++;
            if ({ctrlOut, MEM_store_data, MEM_alu_out} !== {ctrlExp(e), e.storeData, 32'h2000}) begin
                miscompares++;
                $display("[TB] FAIL stall_hold[%0d]: got %b/%h/%h required %b/%h/%h", k, ctrlOut,
                         MEM_store_data, MEM_alu_out, ctrlExp(e), e.storeData, 32'h2000);
            end
            vectors++;
            if ({cycle_cnt, instret_cnt} !== {cntExp(expCycle), cntExp(expInstret)}) begin
                miscompares++;
                $display("[TB] FAIL stall_cnt[%0d]: got %0d/%0d required %0d/%0d", k, cycle_cnt,
                         instret_cnt, cntExp(expCycle), cntExp(expInstret));
            end
        end
        applyStimulus();
        EXE_valid = 1; EXE_MenWrite = 1; EXE_funct3 = F3_B; alu_out = 32'h3001;
        rs2_data = 32'h000000A5;
        e = '0;
        e.valid = 1; e.memWrite = 1; e.byteEn = 4'b0010; e.storeData = 32'h0000A500;
        sbq.push_back(e);
        expInstret = expInstret + 64'd1;
        tick();
        e = sbq.pop_front();
        vectors++;
        if ({ctrlOut, MEM_store_data} !== {ctrlExp(e), e.storeData}) begin
            miscompares++;
            $display("[TB] FAIL stall_release: got %b/%h required %b/%h", ctrlOut, MEM_store_data,
                     ctrlExp(e), e.storeData);
        end
        vectors++;
        if (instret_cnt !== cntExp(expInstret)) begin
            miscompares++;
            $display("[TB] FAIL release_instret: got %0d required %0d", instret_cnt,
                     cntExp(expInstret));
        end
    endtask

    task automatic test_flush_csr_reset();
        exp_t e;
        applyStimulus();
        EXE_valid = 1; EXE_RegWrite = 1; EXE_pc = 32'h400; alu_out = 32'h44;
        e = '0;
        e.valid = 1; e.regWrite = 1; e.rdData = 32'h44;
        sbq.push_back(e);
        expInstret = expInstret + 64'd1;
        tick();
        e = sbq.pop_front();
        vectors++;
        if ({ctrlOut, MEM_rd_data} !== {ctrlExp(e), e.rdData}) begin
            miscompares++;
            $display("[TB] FAIL flush_pre: got %b/%h required %b/%h", ctrlOut, MEM_rd_data,
                     ctrlExp(e), e.rdData);
        end
        applyStimulus();
        EXE_valid = 1; EXE_RegWrite = 1; EXE_MenWrite = 1; EXE_funct3 = F3_W;
        alu_out = 32'h1000; rs2_data = 32'h77777777; EXE_pc = 32'h500; EXE_flush = 1;
        e = '0;
        e.rdData = 32'h44;
        sbq.push_back(e);
        tick();
        e = sbq.pop_front();
        vectors++;
        if (ctrlOut !== ctrlExp(e)) begin
            miscompares++;
            $display("[TB] FAIL flush_ctrl: got %b required %b", ctrlOut, ctrlExp(e));
        end
        vectors++;
        if ({MEM_pc, MEM_rd_data} !== {32'h400, e.rdData}) begin
            miscompares++;
            $display("[TB] FAIL flush_data_hold: got %h/%h required %h/%h", MEM_pc, MEM_rd_data,
                     32'h400, e.rdData);
        end
        vectors++;
        if (instret_cnt !== cntExp(expInstret)) begin
            miscompares++;
            $display("[TB] FAIL flush_instret: got %0d required %0d", instret_cnt,
                     cntExp(expInstret));
        end
        applyStimulus();
        EXE_valid = 1; EXE_MenWrite = 1; EXE_funct3 = F3_W; alu_out = 32'h600;
        rs2_data = 32'hF00DF00D; EXE_pc = 32'h600;
        e = '0;
        e.valid = 1; e.memWrite = 1; e.byteEn = 4'b1111; e.storeData = 32'hF00DF00D;
        sbq.push_back(e);
        expInstret = expInstret + 64'd1;
        tick();
        e = sbq.pop_front();
        vectors++;
        if (ctrlOut !== ctrlExp(e)) begin
            miscompares++;
            $display("[TB] FAIL csr_pre: got %b required %b", ctrlOut, ctrlExp(e));
        end
        applyStimulus();
        CSR_reset = 1; dm_stall = 1; EXE_valid = 1; EXE_RegWrite = 1; EXE_pc = 32'h700;
        tick();
        vectors++;
        if (pipeAll !== '0) begin
            miscompares++;
            $display("[TB] FAIL csr_reset_pipe: got %h required 0", pipeAll);
        end
        vectors++;
        if ({cycle_cnt, instret_cnt} !== {cntExp(expCycle), cntExp(expInstret)}) begin
            miscompares++;
            $display("[TB] FAIL csr_reset_cnt: got %0d/%0d required %0d/%0d", cycle_cnt,
                     instret_cnt, cntExp(expCycle), cntExp(expInstret));
        end
    endtask

    task automatic test_async_reset();
        applyStimulus();
        EXE_valid = 1; EXE_RegWrite = 1; EXE_pc = 32'h700; alu_out = 32'h77;
        expInstret = expInstret + 64'd1;
        tick();
        dm_stall = 1;
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (pipeAll !== '0) begin
            miscompares++;
            $display("[TB] FAIL async_pipe: got %h required 0", pipeAll);
        end
        vectors++;
        if ({cycle_cnt, instret_cnt} !== 128'd0) begin
            miscompares++;
            $display("[TB] FAIL async_cnt: got %0d/%0d required 0/0", cycle_cnt, instret_cnt);
        end
        @(negedge clk);
        vectors++;
        if ({pipeAll, cycle_cnt} !== '0) begin
            miscompares++;
            $display("[TB] FAIL async_hold: got %h/%0d required 0/0", pipeAll, cycle_cnt);
        end
        reset = 1'b0;
        applyStimulus();
        expCycle = '0;
        expInstret = '0;
`ifdef EXEMEM_PERF_CNT_EN
        force dut.cycle_q = '1;
        #1 release dut.cycle_q;
        expCycle = '1;
`endif
        vectors++;
        if (cycle_cnt !== cntExp(expCycle)) begin
            miscompares++;
            $display("[TB] FAIL wrap_pre: got %h required %h", cycle_cnt, cntExp(expCycle));
        end
        tick();
        vectors++;
        if (cycle_cnt !== cntExp(expCycle)) begin
            miscompares++;
            $display("[TB] FAIL wrap_post: got %h required %h", cycle_cnt, cntExp(expCycle));
        end
    endtask

    initial begin
        test_reset();
        test_store_align();
        test_load_misalign();
        test_rd_select();
        test_stall();
        test_flush_csr_reset();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
